// File: rtl/mult16_share_arbiter_if.sv
// Bus between the requesting datapaths, the result consumer and the shared
// 16x16 multiplier front-end.
//   req_valid / req_ready : per-requester operand handshake, bit i = requester i
//   req_a / req_b         : packed 16-bit operands, lane i at [16i+15:16i]
//   rsp_valid / rsp_ready : result handshake
//   rsp_id / rsp_p        : owning requester index and 32-bit unsigned product
// master = requesters + consumer side, slave = the arbiter.
interface mult16_share_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW  = 16;
    localparam int unsigned PW  = 32;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [PW-1:0]      rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mult16_share_arbiter.sv
// Time-shares one 16x16 unsigned multiplier among NREQ requesters.
// Round-robin picks one operand pair at a time, the product is computed over
// a fixed LAT-cycle window and the tagged result is held until consumed.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : slave side of mult16_share_arbiter_if (request/response handshakes)
//   busy     : high in every state except IDLE
//   done_cnt : completed response handshakes, wraps at 16 bits
module mult16_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mult16_share_arbiter_if.slave bus,
    output logic                  busy,
    output logic [15:0]           done_cnt
);
    localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW    = 16;
    localparam int unsigned PW    = 32;
    localparam int unsigned CW    = 16;
    localparam int unsigned CNT_W = 3;
    // CALC lasts LAT-1 cycles; the counter expires when it reads zero.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 1) ? (LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     a_q, b_q;
    logic [IDW-1:0]    id_q;
    logic [PW-1:0]     rsp_p_q;
    logic [IDW-1:0]    rsp_id_q;
    logic              rsp_valid_q;
    logic              busy_q;
    logic [CW-1:0]     done_cnt_q;

    logic              found_c;
    logic [IDW-1:0]    gidx_c;
    logic [IDW-1:0]    cand_c;
    logic [NREQ-1:0]   grant_c;
    logic              accept_c;
    logic              load_rsp_c;
    logic              rsp_hs_c;
    logic [DW-1:0]     a_sel_c, b_sel_c;
    logic [DW-1:0]     op_a_c, op_b_c;
    logic [IDW-1:0]    id_src_c;
    logic [PW-1:0]     prod_c;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        found_c = 1'b0;
        gidx_c  = '0;
        cand_c  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = IDW'((32'(ptr_q) + k) % NREQ);
            if (!found_c && bus.req_valid[cand_c]) begin
                found_c = 1'b1;
                gidx_c  = cand_c;
            end
        end
    end

    // Operands of the currently selected requester.
    assign a_sel_c = bus.req_a[32'(gidx_c) * DW +: DW];
    assign b_sel_c = bus.req_b[32'(gidx_c) * DW +: DW];

    // With LAT=1 the product is taken straight from the bus at acceptance.
    assign op_a_c   = (LAT == 1) ? a_sel_c : a_q;
    assign op_b_c   = (LAT == 1) ? b_sel_c : b_q;
    assign id_src_c = (LAT == 1) ? gidx_c  : id_q;
    assign prod_c   = PW'(op_a_c) * PW'(op_b_c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_c    = '0;
        accept_c   = 1'b0;
        load_rsp_c = 1'b0;
        rsp_hs_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Grant is never issued while reset is asserted.
                if (found_c && !rst) begin
                    grant_c[gidx_c] = 1'b1;
                    accept_c        = 1'b1;
                    ptr_d           = (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
                    if (LAT == 1) begin
                        load_rsp_c = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    load_rsp_c = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_hs_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (accept_c) begin
                a_q  <= a_sel_c;
                b_q  <= b_sel_c;
                id_q <= gidx_c;
            end
            if (load_rsp_c) begin
                rsp_p_q  <= prod_c;
                rsp_id_q <= id_src_c;
            end
            rsp_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
            if (rsp_hs_c) begin
                done_cnt_q <= done_cnt_q + CW'(1);
            end
        end
    end

    assign bus.req_ready = grant_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign busy          = busy_q;
    assign done_cnt      = done_cnt_q;
endmodule

// File: tb/tb_mult16_share_arbiter.sv
// Self-checking bench for mult16_share_arbiter (NREQ=4, LAT=2).
// A cycle-level reference model checks req_ready/rsp_valid/busy/done_cnt every
// cycle; expected responses are queued at acceptance and popped on the
// response handshake.
module tb_mult16_share_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int M_IDLE = 0;
    localparam int M_CALC = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] p;
    } rsp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] a;
        logic [15:0] b;
        int          id;
        logic [31:0] p;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] done_cnt;

    mult16_share_arbiter_if #(.NREQ(NREQ)) bus ();

    mult16_share_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   mon_en = 0;
    rsp_t exp_q[$];
    vec_t tbl[8];

    int          m_state = M_IDLE;
    int          m_ptr = 0;
    int          m_cnt = 0;
    int          m_g = 0;
    logic [15:0] m_done = '0;
    logic [3:0]  er;
    rsp_t        e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] arb(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (v[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    // Reference model, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            er = (rst || m_state != M_IDLE) ? 4'b0000 : arb(bus.req_valid, m_ptr);
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == M_DONE));
            chk("busy", 32'(busy), 32'(m_state != M_IDLE));
            chk("done_cnt", 32'(done_cnt), 32'(m_done));
            if (rst) begin
                m_state = M_IDLE;
                m_ptr   = 0;
                m_done  = '0;
                exp_q.delete();
            end else begin
                case (m_state)
                    M_IDLE: begin
                        if (er != 4'b0000) begin
                            for (int i = 0; i < 4; i++) if (er[i]) m_g = i;
                            m_ptr = (m_g + 1) % 4;
                            if (LAT == 1) m_state = M_DONE;
                            else begin
                                m_cnt   = LAT - 1;
                                m_state = M_CALC;
                            end
                        end
                    end
                    M_CALC: begin
                        m_cnt--;
                        if (m_cnt == 0) m_state = M_DONE;
                    end
                    default: begin
                        if (bus.rsp_ready) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_rsp", 32'(1), 32'(0));
                            end else begin
                                e = exp_q.pop_front();
                                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                                chk("rsp_p", bus.rsp_p, e.p);
                            end
                            m_done  = m_done + 16'd1;
                            m_state = M_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[16*i +: 16] = a;
            bus.req_b[16*i +: 16] = b;
        end
    endtask

    // Present mask until a handshake happens; queue the expected response.
    task automatic issue(input logic [3:0] mask, input int id, input logic [31:0] p);
        bit   got;
        rsp_t r;
        got = 0;
        bus.req_valid = mask;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if ((bus.req_valid & bus.req_ready) != 4'b0000) begin
                got      = 1;
                last_acc = cyc;
                r.id     = 2'(id);
                r.p      = p;
                exp_q.push_back(r);
            end
            tick();
        end
        bus.req_valid = '0;
        if (!got) chk("issue_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            #1;
            ok = (m_state == M_IDLE) && (exp_q.size() == 0);
        end
        if (!ok) chk("idle_timeout", 32'(0), 32'(1));
        tick();
    endtask

    task automatic wait_rsp();
        bit seen;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        if (!seen) chk("rsp_timeout", 32'(0), 32'(1));
        tick();
    endtask

    initial begin
        tbl[0] = '{4'b0001, 16'h0003, 16'h0005, 0, 32'h0000_000F};
        tbl[1] = '{4'b1001, 16'h1234, 16'h0010, 3, 32'h0001_2340};
        tbl[2] = '{4'b1110, 16'hFFFF, 16'h0001, 1, 32'h0000_FFFF};
        tbl[3] = '{4'b0011, 16'h0000, 16'hABCD, 0, 32'h0000_0000};
        tbl[4] = '{4'b0110, 16'h00FF, 16'h00FF, 1, 32'h0000_FE01};
        tbl[5] = '{4'b0100, 16'h8000, 16'h8000, 2, 32'h4000_0000};
        tbl[6] = '{4'b1111, 16'hFFFF, 16'hFFFE, 3, 32'hFFFD_0002};
        tbl[7] = '{4'b1000, 16'h0002, 16'h7FFF, 3, 32'h0000_FFFE};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset: req_ready must stay low even with every request raised.
        tick();
        mon_en        = 1;
        bus.req_valid = 4'hF;
        tick();
        tick();
        rst           = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        chk("rst_rsp_p", bus.rsp_p, 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();

        // Single op: max operands, result two cycles after acceptance.
        set_lanes(16'hFFFF, 16'hFFFF);
        issue(4'b0001, 0, 32'hFFFE_0001);
        @(negedge clk);
        chk("lat_early", 32'(bus.rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("lat_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lat_p", bus.rsp_p, 32'hFFFE_0001);
        chk("lat_id", 32'(bus.rsp_id), 32'h0);
        tick();
        wait_idle();
        @(negedge clk);
        chk("single_done_cnt", 32'(done_cnt), 32'h1);
        tick();

        // Table-driven operations (pointer starts at 1).
        for (int v = 0; v < 8; v++) begin
            set_lanes(tbl[v].a, tbl[v].b);
            issue(tbl[v].mask, tbl[v].id, tbl[v].p);
            wait_idle();
        end

        // Fairness: all requesting, back-to-back grants 0,1,2,3,0,1.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[16*i +: 16] = 16'(i + 1);
            bus.req_b[16*i +: 16] = 16'h0100;
        end
        for (int k = 0; k < 6; k++) begin
            int prev;
            prev = last_acc;
            issue(4'hF, k % 4, 32'((k % 4) + 1) * 32'h100);
            if (k > 0) chk("fair_gap", 32'(last_acc - prev), 32'(LAT + 1));
        end
        wait_idle();

        // Backpressure: result held, no grants while DONE waits.
        bus.rsp_ready = 1'b0;
        set_lanes(16'h0101, 16'h0202);
        issue(4'b0100, 2, 32'h0002_0402);
        wait_rsp();
        bus.req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_p", bus.rsp_p, 32'h0002_0402);
            chk("bp_id", 32'(bus.rsp_id), 32'h2);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_idle", 32'(busy), 32'h0);
        tick();

        // Reset pulsed during CALC discards the operation.
        set_lanes(16'h0007, 16'h0009);
        issue(4'b0001, 0, 32'd63);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_drop", 32'(bus.rsp_valid), 32'h0);
            tick();
        end

        // After reset ptr=0: requesters 2 and 0 together grant 0 first.
        bus.rsp_ready = 1'b0;
        set_lanes(16'h0011, 16'h0011);
        issue(4'b0101, 0, 32'h0000_0121);
        wait_rsp();

        // Requester 3 asks while busy, withdraws; requester 1 then wins.
        bus.req_valid = 4'b1000;
        tick();
        tick();
        tick();
        set_lanes(16'h8000, 16'h0002);
        bus.rsp_ready = 1'b1;
        issue(4'b0010, 1, 32'h0001_0000);
        wait_idle();

        // Completion counter wraps from 0xFFFF to 0.
        #1;
        force dut.done_cnt_q = 16'hFFFF;
        m_done = 16'hFFFF;
        #1;
        release dut.done_cnt_q;
        tick();
        set_lanes(16'h0001, 16'h0001);
        issue(4'b0001, 0, 32'h0000_0001);
        wait_idle();
        @(negedge clk);
        chk("wrap_done_cnt", 32'(done_cnt), 32'h0);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
